// File: rtl/tt_um_timer_multi.sv
// Multi-channel programmable timer: a shared free-running prescaler feeds
// independent one-shot/periodic channels with sticky, clearable expiry flags.
module tt_um_timer_multi #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 4,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic                      cfg_we,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [WIDTH-1:0]          cfg_limit,
  input  logic                      cfg_mode,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       irq_clr,
  output logic [CHANNELS-1:0]       reached,
  output logic [CHANNELS-1:0]       pending,
  output logic                      irq,
  output logic [CHANNELS*WIDTH-1:0] count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [PRESCALE_W-1:0] pc_r;
  logic                  tick_s;
  logic                  cfg_ok_s;

  state_t                state_r   [CHANNELS];
  state_t                state_s   [CHANNELS];
  logic [WIDTH-1:0]      count_r   [CHANNELS];
  logic [WIDTH-1:0]      count_s   [CHANNELS];
  logic [WIDTH-1:0]      limit_r   [CHANNELS];
  logic [CHANNELS-1:0]   mode_r;
  logic [CHANNELS-1:0]   reached_r;
  logic [CHANNELS-1:0]   reached_s;
  logic [CHANNELS-1:0]   pending_r;
  logic [CHANNELS-1:0]   pending_s;
  logic [CHANNELS-1:0]   expire_s;

  // ">=" rather than "==" so that lowering prescale below pc ticks at once
  assign tick_s   = (pc_r >= prescale);
  assign cfg_ok_s = ({1'b0, cfg_ch} < (CH_W+1)'(CHANNELS));

  // Shared free-running prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r <= {PRESCALE_W{1'b0}};
    end else if (tick_s) begin
      pc_r <= {PRESCALE_W{1'b0}};
    end else begin
      pc_r <= pc_r + PRESCALE_W'(1);
    end
  end

  // Per-channel limit/mode configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        limit_r[i] <= {WIDTH{1'b1}};
      end
      mode_r <= {CHANNELS{1'b0}};
    end else if (cfg_we && cfg_ok_s) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_ch == CH_W'(i)) begin
          limit_r[i] <= cfg_limit;
          mode_r[i]  <= cfg_mode;
        end
      end
    end
  end

  // Channel FSM next-state, count, reached and pending logic
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_s[i]   = state_r[i];
      count_s[i]   = count_r[i];
      reached_s[i] = reached_r[i];
      expire_s[i]  = 1'b0;
      if (!start[i]) begin
        state_s[i]   = ST_IDLE;
        count_s[i]   = {WIDTH{1'b0}};
        reached_s[i] = 1'b0;
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            state_s[i]   = ST_RUN;
            count_s[i]   = {WIDTH{1'b0}};
            reached_s[i] = 1'b0;
          end
          ST_RUN: begin
            if (tick_s) begin
              if (count_r[i] >= limit_r[i]) begin
                expire_s[i]  = 1'b1;
                reached_s[i] = 1'b1;
                if (mode_r[i]) begin
                  count_s[i] = {WIDTH{1'b0}};
                end else begin
                  state_s[i] = ST_DONE;
                end
              end else begin
                count_s[i]   = count_r[i] + WIDTH'(1);
                reached_s[i] = 1'b0;
              end
            end else begin
              reached_s[i] = 1'b0;
            end
          end
          ST_DONE: begin
            reached_s[i] = 1'b1;
          end
          default: begin
            state_s[i]   = ST_IDLE;
            count_s[i]   = {WIDTH{1'b0}};
            reached_s[i] = 1'b0;
          end
        endcase
      end
      // Set has priority over a same-edge clear
      pending_s[i] = expire_s[i] | (pending_r[i] & ~irq_clr[i]);
    end
  end

  // Channel state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= ST_IDLE;
        count_r[i] <= {WIDTH{1'b0}};
      end
      reached_r <= {CHANNELS{1'b0}};
      pending_r <= {CHANNELS{1'b0}};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_r[i] <= state_s[i];
        count_r[i] <= count_s[i];
      end
      reached_r <= reached_s;
      pending_r <= pending_s;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_count
    assign count[g*WIDTH +: WIDTH] = count_r[g];
  end

  assign reached = reached_r;
  assign pending = pending_r;
  assign irq     = |pending_r;

endmodule
